// File: rtl/collision_pkg.sv
// Shared types and default channel counts for the collision controller and
// the rocket/shield drawers that size their request vectors from it.
package collision_pkg;

   typedef enum logic {
      ARMING = 1'b0,
      ACCUM  = 1'b1
   } state_t;

   localparam int DEF_NUM_P_ROCKETS = 2;
   localparam int DEF_NUM_A_ROCKETS = 3;
   localparam int DEF_NUM_SHIELDS   = 4;
   localparam int DEF_BORDER_Y      = 479;
   localparam int DEF_HIT_CNT_W     = 8;
   localparam int PIXEL_W           = 11;

endpackage

// File: rtl/collision_frame_controller_if.sv
// Pixel-request bundle from the drawers and per-frame hit report to game logic.
interface collision_frame_controller_if import collision_pkg::*; #(
   parameter int NUM_P_ROCKETS = DEF_NUM_P_ROCKETS,
   parameter int NUM_A_ROCKETS = DEF_NUM_A_ROCKETS,
   parameter int NUM_SHIELDS   = DEF_NUM_SHIELDS,
   parameter int HIT_CNT_W     = DEF_HIT_CNT_W
);
   logic                      startOfFrame;
   logic                      drawing_request_player;
   logic                      drawing_request_aliens;
   logic [NUM_P_ROCKETS-1:0]  p_rockets_DR;
   logic [NUM_A_ROCKETS-1:0]  a_rockets_DR;
   logic [NUM_SHIELDS-1:0]    shields_DR;
   logic signed [PIXEL_W-1:0] pixelX;
   logic signed [PIXEL_W-1:0] pixelY;

   // Report handshake: reportValid is a one-cycle pulse with no ready; every
   // event vector is valid only while it is high and is zero otherwise.
   logic [NUM_P_ROCKETS-1:0]  alienHit;
   logic                      playerHitByAlien;
   logic [NUM_A_ROCKETS-1:0]  playerHitByRocket;
   logic [NUM_P_ROCKETS-1:0]  p_rocketsCollision;
   logic [NUM_A_ROCKETS-1:0]  a_rocketsCollision;
   logic [NUM_SHIELDS-1:0]    shieldHit;
   logic                      aliensReachedBorder;
   logic [HIT_CNT_W-1:0]      playerHitCount;
   logic                      reportValid;

   modport master (
      output startOfFrame, drawing_request_player, drawing_request_aliens,
             p_rockets_DR, a_rockets_DR, shields_DR, pixelX, pixelY,
      input  alienHit, playerHitByAlien, playerHitByRocket, p_rocketsCollision,
             a_rocketsCollision, shieldHit, aliensReachedBorder, playerHitCount,
             reportValid
   );

   modport slave (
      input  startOfFrame, drawing_request_player, drawing_request_aliens,
             p_rockets_DR, a_rockets_DR, shields_DR, pixelX, pixelY,
      output alienHit, playerHitByAlien, playerHitByRocket, p_rocketsCollision,
             a_rocketsCollision, shieldHit, aliensReachedBorder, playerHitCount,
             reportValid
   );
endinterface

// File: rtl/sticky_event_reg.sv
// Frame-sticky event flags: OR-accumulate, dump as a one-cycle pulse on strobe.
module sticky_event_reg #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] set,
   input  logic             strobe,
   output logic [WIDTH-1:0] pulse,
   output logic             pending
);
   logic [WIDTH-1:0] held;

   // On the strobe the old frame is reported and a coincident set starts the new one.
   always_ff @(posedge clk) begin
      if (reset) begin
         held  <= '0;
         pulse <= '0;
      end else if (strobe) begin
         pulse <= held;
         held  <= set;
      end else begin
         pulse <= '0;
         held  <= held | set;
      end
   end

   assign pending = |held;
endmodule

// File: rtl/collision_frame_controller.sv
// Per-pixel collision detection with once-per-frame hit reporting.
module collision_frame_controller import collision_pkg::*; #(
   parameter int NUM_P_ROCKETS = DEF_NUM_P_ROCKETS,
   parameter int NUM_A_ROCKETS = DEF_NUM_A_ROCKETS,
   parameter int NUM_SHIELDS   = DEF_NUM_SHIELDS,
   parameter int BORDER_Y      = DEF_BORDER_Y,
   parameter int HIT_CNT_W     = DEF_HIT_CNT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   collision_frame_controller_if.slave  bus,
   output state_t                       state
);
   localparam logic signed [PIXEL_W-1:0] BORDER_LIM = PIXEL_W'(BORDER_Y);

   state_t state_q, state_d;
   logic   sof_q, sof_edge, strobe, detect_en;
   logic   report_q;
   logic   player_pending;
   logic [HIT_CNT_W-1:0] hit_cnt;
   logic [4:0] unused_pending;
   logic       unused_pixel_x;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARMING;
         sof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sof_q   <= bus.startOfFrame;
      end
   end

   assign sof_edge = bus.startOfFrame & ~sof_q;

   // ARMING masks detection through its exit edge so ACCUM starts with clean flags.
   always_comb begin
      state_d   = state_q;
      strobe    = 1'b0;
      detect_en = 1'b0;
      case (state_q)
         ARMING: if (sof_edge) state_d = ACCUM;
         ACCUM: begin
            detect_en = 1'b1;
            strobe    = sof_edge;
         end
         default: state_d = ARMING;
      endcase
   end

   logic any_p, any_a, any_s, pl, al;
   assign any_p = |bus.p_rockets_DR;
   assign any_a = |bus.a_rockets_DR;
   assign any_s = |bus.shields_DR;
   assign pl    = bus.drawing_request_player;
   assign al    = bus.drawing_request_aliens;

   logic [NUM_P_ROCKETS-1:0]   set_alien, set_prock;
   logic [NUM_A_ROCKETS:0]     set_player;
   logic [NUM_A_ROCKETS-1:0]   set_arock;
   logic [NUM_SHIELDS-1:0]     set_shield;
   logic                       set_border;

   assign set_alien  = bus.p_rockets_DR & {NUM_P_ROCKETS{al & detect_en}};
   assign set_prock  = bus.p_rockets_DR & {NUM_P_ROCKETS{(al | any_a | any_s) & detect_en}};
   assign set_arock  = bus.a_rockets_DR & {NUM_A_ROCKETS{(pl | any_p | any_s) & detect_en}};
   assign set_shield = bus.shields_DR & {NUM_SHIELDS{(any_p | any_a) & detect_en}};
   assign set_player = {pl & al & detect_en, bus.a_rockets_DR & {NUM_A_ROCKETS{pl & detect_en}}};
   assign set_border = al & (bus.pixelY > BORDER_LIM) & detect_en;

   sticky_event_reg #(.WIDTH(NUM_P_ROCKETS)) u_alien (
      .clk(clk), .reset(reset), .set(set_alien), .strobe(strobe),
      .pulse(bus.alienHit), .pending(unused_pending[0]));

   sticky_event_reg #(.WIDTH(NUM_A_ROCKETS + 1)) u_player (
      .clk(clk), .reset(reset), .set(set_player), .strobe(strobe),
      .pulse({bus.playerHitByAlien, bus.playerHitByRocket}), .pending(player_pending));

   sticky_event_reg #(.WIDTH(NUM_P_ROCKETS)) u_prock (
      .clk(clk), .reset(reset), .set(set_prock), .strobe(strobe),
      .pulse(bus.p_rocketsCollision), .pending(unused_pending[1]));

   sticky_event_reg #(.WIDTH(NUM_A_ROCKETS)) u_arock (
      .clk(clk), .reset(reset), .set(set_arock), .strobe(strobe),
      .pulse(bus.a_rocketsCollision), .pending(unused_pending[2]));

   sticky_event_reg #(.WIDTH(NUM_SHIELDS)) u_shield (
      .clk(clk), .reset(reset), .set(set_shield), .strobe(strobe),
      .pulse(bus.shieldHit), .pending(unused_pending[3]));

   sticky_event_reg #(.WIDTH(1)) u_border (
      .clk(clk), .reset(reset), .set(set_border), .strobe(strobe),
      .pulse(bus.aliensReachedBorder), .pending(unused_pending[4]));

   always_ff @(posedge clk) begin
      if (reset) begin
         report_q <= 1'b0;
         hit_cnt  <= '0;
      end else begin
         report_q <= strobe;
         if (strobe && player_pending && !(&hit_cnt))
            hit_cnt <= hit_cnt + HIT_CNT_W'(1);
      end
   end

   assign bus.reportValid    = report_q;
   assign bus.playerHitCount = hit_cnt;
   assign state              = state_q;
   assign unused_pixel_x     = ^bus.pixelX;
endmodule

// File: doc/collision_frame_controller.md
# collision_frame_controller

Parametrised per-frame collision controller between the VGA object drawers and the game-logic blocks (player, aliens, rockets, shields). Per pixel, it detects overlaps between any number of player rockets, alien rockets and shield segments and the player/alien sprites. Hits are accumulated into sticky per-channel flags for the whole frame. At each frame boundary it reports every object hit exactly once as a one-cycle pulse, so multi-pixel overlaps never produce repeated events.

## Interface
- NUM_P_ROCKETS, 2, player rocket channels (≥1)
- NUM_A_ROCKETS, 3, alien rocket channels (≥1)
- NUM_SHIELDS, 4, shield segment channels (≥1)
- BORDER_Y, 479, alien border row; an alien pixel with pixelY > BORDER_Y is a border event
- HIT_CNT_W, 8, width of saturating player-hit counter
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  frame-boundary strobe; rising edge sampled
- drawing_request_player  in  1  player sprite pixel
- drawing_request_aliens  in  1  alien matrix pixel
- p_rockets_DR  in  NUM_P_ROCKETS  per-rocket pixel requests
- a_rockets_DR  in  NUM_A_ROCKETS  per-rocket pixel requests
- shields_DR  in  NUM_SHIELDS  per-segment pixel requests
- pixelX, pixelY  in  11 signed each  current VGA pixel
- alienHit  out  NUM_P_ROCKETS  pulse: player rocket i hit alien matrix
- playerHitByAlien  out  1  pulse: alien sprite overlapped player
- playerHitByRocket  out  NUM_A_ROCKETS  pulse: alien rocket j hit player
- p_rocketsCollision  out  NUM_P_ROCKETS  pulse: player rocket i destroyed (alien, alien rocket or shield)
- a_rocketsCollision  out  NUM_A_ROCKETS  pulse: alien rocket j destroyed (player rocket, player or shield)
- shieldHit  out  NUM_SHIELDS  pulse: segment k hit by any rocket
- aliensReachedBorder  out  1  pulse: border event this frame
- playerHitCount  out  HIT_CNT_W  saturating count of frames with any player hit
- reportValid  out  1  pulse coinciding with every report cycle

## Operation
- States: ARMING (after reset), ACCUM.
- ARMING: all detection masked; the partial frame after reset is discarded. On the first startOfFrame rising edge, go to ACCUM with flags clear; no report is issued.
- ACCUM: each cycle, OR the raw collision terms into sticky flags.
  - alien_i = aliens & p[i]
  - pRocket_i = p[i] & (aliens | any(a) | any(shields))
  - aRocket_j = a[j] & (player | any(p) | any(shields))
  - shield_k = s[k] & (any(p) | any(a))
  - playerRocket_j = player & a[j]
  - playerAlien = player & aliens
  - border = aliens & (pixelY > BORDER_Y)
- Rocket-vs-rocket is channel-exact. A player rocket is flagged only if some alien rocket overlaps on that pixel, and vice versa. A rocket that is not itself drawn is never flagged.
- Report, on each startOfFrame rising edge in ACCUM:
  - Copy all sticky flags to the output registers for one cycle.
  - Pulse reportValid.
  - Clear the sticky flags.
  - Increment playerHitCount if any playerRocket or playerAlien flag was set; it holds at all-ones.
- Simultaneous startOfFrame edge and raw collision in the same cycle: the collision belongs to the new frame. It is loaded into the freshly cleared flags, not into the current report.
- startOfFrame held high for several cycles produces one report; a new report needs a low-then-high transition.
- Reset at any time: return to ARMING; clear flags, edge-detect register, output pulses and playerHitCount.

## Timing
- All outputs registered. Reset value of every output is 0.
- Raw collision at cycle t sets the flag at t+1.
- startOfFrame rising edge sampled at cycle t gives outputs and reportValid high during cycle t+1 only, and 0 at t+2.
- Report latency relative to the colliding pixel is at most one frame plus 1 cycle.
- pixelY comparison is signed, 11-bit; negative rows never trigger a border event.

## Structure
- Package collision_pkg holds the state enum (ARMING, ACCUM) and default channel-count localparams shared with the rocket and shield drawers.
- Sub-module sticky_event_reg, parameter WIDTH:
  - inputs: set vector, frame strobe
  - behaviour: OR-accumulates set, transfers to the pulse output on the strobe and clears, with set-wins-into-new-frame priority
  - instantiated once per output group
- Top level contains the edge detector, FSM, collision terms and hit counter.

## Test plan
- Reset, then collisions before the first startOfFrame: a[0]&player for 50 cycles, then one frame edge → no pulses; the next edge with no collisions → all outputs 0, reportValid=1.
- In ACCUM, p[1]&aliens for 200 cycles within one frame → alienHit=2'b10 and p_rocketsCollision=2'b10 for exactly one cycle after the edge; playerHitCount unchanged.
- p=2'b01, a=3'b100 on the same pixel, then shields_DR[2]&a[1] on a later pixel → p_rocketsCollision=01, a_rocketsCollision=110, shieldHit=0100.
- Raw player&a[0] on the same cycle as the startOfFrame edge → the current report has playerHitByRocket=000; the following report has 001 and playerHitCount increments then.
- aliens at pixelY=480 → aliensReachedBorder pulse; at pixelY=479 or −5 → no pulse. Run 300 frames with player hits at HIT_CNT_W=8 → count saturates at 255.
- reset asserted mid-frame with flags set → all outputs 0 next cycle, state ARMING, count 0.
